// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module : mem_access_ctrl_pkg
// Brief  : Shared encodings for the RAM access controller and its arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic REQ_I    = 1'b0;
  localparam logic REQ_D    = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_rr_arb.sv
// ============================================================================
// Module : mem_rr_arb
// Brief  : Two-way round-robin arbiter; pointer names the favoured requester.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_rr_arb
  import mem_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_id
);

  logic r_ptr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_id = REQ_I;
    if (req == 2'b11)
      gnt_id = r_ptr;
    else if (req[REQ_D])
      gnt_id = REQ_D;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= REQ_D;
    else if (update)
      r_ptr <= ~gnt_id;
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : Shares a single-port RAM between fetch (I) and load/store (D)
//          ports with an Enable/MOV/RW/MOC handshake and a MOC timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic [DW-1:0] IRdata,
  output logic          IAck,
  input  logic          DReq,
  input  logic          DRW,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic [DW-1:0] DRdata,
  output logic          DAck,
  output logic          Enable,
  output logic          MOV,
  output logic          RW,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  input  logic          MOC,
  output logic          Busy,
  output logic          Timeout
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_cnt;
  logic          r_gnt;
  logic          w_gnt_id;
  logic          w_arb_update;
  logic          w_hit;
  logic          w_expire;
  logic [DW-1:0] w_word;

  mem_rr_arb u_arb (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .req    ({DReq, IReq}),
    .update (w_arb_update),
    .gnt_id (w_gnt_id)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_arb_update = 1'b0;
    w_hit        = 1'b0;
    w_expire     = 1'b0;
    w_word       = '0;
    case (r_state)
      ST_IDLE: begin
        if (IReq || DReq) begin
          w_state_nxt  = ST_SETUP;
          w_arb_update = 1'b1;
        end
      end
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (MOC) begin
          w_hit       = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == TW'(TIMEOUT - 1)) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // Writes and aborted accesses return zero to the requester.
    if (w_hit && (RW != RW_WRITE))
      w_word = MemRdata;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_gnt    <= REQ_I;
      Enable   <= 1'b0;
      MOV      <= 1'b0;
      RW       <= 1'b0;
      Address  <= '0;
      MemWdata <= '0;
      IRdata   <= '0;
      DRdata   <= '0;
      IAck     <= 1'b0;
      DAck     <= 1'b0;
      Busy     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      Enable  <= (w_state_nxt != ST_IDLE);
      Busy    <= (w_state_nxt != ST_IDLE);
      MOV     <= (w_state_nxt == ST_ACCESS);
      IAck    <= (w_state_nxt == ST_DONE) && (r_gnt == REQ_I);
      DAck    <= (w_state_nxt == ST_DONE) && (r_gnt == REQ_D);
      Timeout <= w_expire;

      if (r_state == ST_ACCESS && !MOC)
        r_cnt <= r_cnt + TW'(1);
      else if (r_state == ST_DONE)
        r_cnt <= '0;

      if (w_arb_update) begin
        r_gnt <= w_gnt_id;
        if (w_gnt_id == REQ_I) begin
          Address  <= IAddr;
          RW       <= RW_READ;
          MemWdata <= '0;
        end else begin
          Address  <= DAddr;
          RW       <= DRW;
          MemWdata <= DWdata;
        end
      end

      if (w_hit || w_expire) begin
        if (r_gnt == REQ_I)
          IRdata <= w_word;
        else
          DRdata <= w_word;
      end
    end
  end

endmodule

`default_nettype wire
